// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane-mask constants for the store aligner
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    ERR
  } sa_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  function automatic logic [3:0] base_mask(input store_size_e sz);
    case (sz)
      SZ_BYTE: base_mask = MASK_B;
      SZ_HALF: base_mask = MASK_H;
      SZ_WORD: base_mask = MASK_W;
      default: base_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/shift_left.sv
// rtl/shift_left.sv - 32-bit logical left shifter used for low-word lane alignment
module shift_left (
  input  logic [31:0] data_i,
  input  logic [4:0]  shift_amount,
  output logic [31:0] data_o
);

  assign data_o = data_i << shift_amount;

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - lane-aligns a store and issues one or two word writes
module store_align_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bmask,
  output logic        done,
  output logic        err
);

  sa_state_e   state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_bmask_q, mem_bmask_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_mask_q, hi_mask_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  store_size_e req_sz;
  logic [1:0]  off;
  logic [31:0] data_m;
  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [5:0]  hi_shamt;
  logic [7:0]  mask8;

  assign req_sz = store_size_e'(req_size);
  assign off    = req_addr[1:0];

  always_comb begin
    data_m = req_data;
    case (req_sz)
      SZ_BYTE: data_m = {24'b0, req_data[7:0]};
      SZ_HALF: data_m = {16'b0, req_data[15:0]};
      default: data_m = req_data;
    endcase
  end

  shift_left u_shift_left (
    .data_i       (data_m),
    .shift_amount ({off, 3'b000}),
    .data_o       (lo_word)
  );

  // Bytes pushed past lane 3 land in the next word; nothing spills when off is 0.
  assign hi_shamt = 6'd32 - {1'b0, off, 3'b000};
  assign hi_word  = (off == 2'b00) ? 32'b0 : (data_m >> hi_shamt);
  assign mask8    = {4'b0000, base_mask(req_sz)} << off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
      mem_bmask_q <= 4'b0;
      hi_data_q   <= 32'b0;
      hi_mask_q   <= 4'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      hi_data_q   <= hi_data_d;
      hi_mask_q   <= hi_mask_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    hi_data_d   = hi_data_q;
    hi_mask_d   = hi_mask_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sz == SZ_ILL) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d     = LOW;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = lo_word;
            mem_bmask_d = mask8[3:0];
            hi_data_d   = hi_word;
            hi_mask_d   = mask8[7:4];
          end
        end
      end
      LOW: begin
        if (mem_ready) begin
          if (|hi_mask_q) begin
            state_d     = HIGH;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_wdata_d = hi_data_q;
            mem_bmask_d = hi_mask_q;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      HIGH: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bmask = mem_bmask_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - self-checking bench for store_align_unit
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        done, err;

  int total = 0;
  int bad = 0;

  int          obs_nb, obs_done_cyc, obs_err_cyc, obs_err_cnt;
  bit          obs_unstable, obs_valid_seen, obs_both, obs_timeout, obs_ready_at_end;
  bit          post_done, post_err, post_valid, post_ready;
  logic [31:0] obs_addr [4];
  logic [31:0] obs_data [4];
  logic [3:0]  obs_mask [4];

  int          exp_nb;
  bit          exp_ill;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_mask [2];

  always #5 clk = ~clk;

  store_align_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bmask (mem_bmask),
    .done      (done),
    .err       (err)
  );

  // Reference: place the store into a 64-bit window starting at the aligned base.
  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [63:0] img;
    logic [7:0]  m;
    logic [31:0] md;
    exp_ill = (sz == 2'b11);
    md = d;
    m  = 8'h0F;
    if (sz == 2'b00) begin md = d & 32'h0000_00FF; m = 8'h01; end
    if (sz == 2'b01) begin md = d & 32'h0000_FFFF; m = 8'h03; end
    img = {32'b0, md} << (8 * a[1:0]);
    m   = m << a[1:0];
    exp_addr[0] = a & 32'hFFFF_FFFC;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_data[0] = img[31:0];
    exp_data[1] = img[63:32];
    exp_mask[0] = m[3:0];
    exp_mask[1] = m[7:4];
    exp_nb = exp_ill ? 0 : ((m[7:4] != 4'b0) ? 2 : 1);
  endtask

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int stall_n, input bit junk);
    int          stall_cnt;
    bit          prev_hold;
    bit          finished;
    logic [31:0] pa, pd;
    logic [3:0]  pm;
    obs_nb = 0; obs_done_cyc = -1; obs_err_cyc = -1; obs_err_cnt = 0;
    obs_unstable = 0; obs_valid_seen = 0; obs_both = 0; obs_timeout = 0; obs_ready_at_end = 0;
    post_done = 0; post_err = 0; post_valid = 0; post_ready = 0;
    pa = 0; pd = 0; pm = 0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = junk; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
    stall_cnt = 0; prev_hold = 0; finished = 0;
    for (int c = 1; c <= 80 && !finished; c++) begin
      if (done && err) obs_both = 1;
      if (err) begin obs_err_cnt++; if (obs_err_cyc < 0) obs_err_cyc = c; end
      if (mem_valid) obs_valid_seen = 1;
      if (prev_hold && (!mem_valid || mem_addr !== pa || mem_wdata !== pd || mem_bmask !== pm))
        obs_unstable = 1;
      if (done && obs_done_cyc < 0) obs_done_cyc = c;
      if (done || err) begin
        req_valid = 1'b0;
        mem_ready = 1'b0;
        obs_ready_at_end = req_ready;
        @(posedge clk); #1;
        post_done = done; post_err = err; post_valid = mem_valid; post_ready = req_ready;
        if (err) obs_err_cnt++;
        finished = 1;
      end else begin
        mem_ready = mem_valid && (stall_cnt >= stall_n);
        if (mem_valid && mem_ready) begin
          if (obs_nb < 4) begin
            obs_addr[obs_nb] = mem_addr; obs_data[obs_nb] = mem_wdata; obs_mask[obs_nb] = mem_bmask;
          end
          obs_nb++;
          stall_cnt = 0; prev_hold = 0;
        end else if (mem_valid) begin
          stall_cnt++; prev_hold = 1; pa = mem_addr; pd = mem_wdata; pm = mem_bmask;
        end else begin
          prev_hold = 0;
        end
        @(posedge clk); #1;
      end
    end
    if (!finished) obs_timeout = 1;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    total++; if ({mem_addr, mem_wdata, mem_bmask} !== 68'b0) begin bad++; $display("FAIL reset_mem_bus got %h/%h/%b want 0", mem_addr, mem_wdata, mem_bmask); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got %b%b want 00", done, err); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0", req_ready, mem_valid); end
  endtask

  task automatic test_aligned_word();
    run_store(32'h100, 32'hDEADBEEF, 2'b10, 0, 1'b0);
    total++; if (obs_nb !== 1) begin bad++; $display("FAIL aligned_beats got %0d want 1", obs_nb); end
    total++; if (obs_addr[0] !== 32'h100 || obs_data[0] !== 32'hDEADBEEF || obs_mask[0] !== 4'b1111) begin bad++; $display("FAIL aligned_beat0 got %h/%h/%b want 00000100/deadbeef/1111", obs_addr[0], obs_data[0], obs_mask[0]); end
    total++; if (obs_done_cyc !== 2) begin bad++; $display("FAIL aligned_done_cycle got %0d want 2", obs_done_cyc); end
    total++; if (obs_ready_at_end !== 1'b1) begin bad++; $display("FAIL aligned_ready_at_done got %b want 1", obs_ready_at_end); end
    total++; if (post_done !== 1'b0) begin bad++; $display("FAIL aligned_done_width got %b want 0", post_done); end
  endtask

  task automatic test_byte_lanes();
    run_store(32'h203, 32'h123456AB, 2'b00, 0, 1'b1);
    total++; if (obs_nb !== 1) begin bad++; $display("FAIL byte_beats got %0d want 1", obs_nb); end
    total++; if (obs_addr[0] !== 32'h200 || obs_data[0] !== 32'hAB000000 || obs_mask[0] !== 4'b1000) begin bad++; $display("FAIL byte_beat0 got %h/%h/%b want 00000200/ab000000/1000", obs_addr[0], obs_data[0], obs_mask[0]); end
  endtask

  task automatic test_split_word();
    run_store(32'h102, 32'h11223344, 2'b10, 0, 1'b0);
    total++; if (obs_nb !== 2) begin bad++; $display("FAIL split_beats got %0d want 2", obs_nb); end
    total++; if (obs_addr[0] !== 32'h100 || obs_data[0] !== 32'h33440000 || obs_mask[0] !== 4'b1100) begin bad++; $display("FAIL split_beat0 got %h/%h/%b want 00000100/33440000/1100", obs_addr[0], obs_data[0], obs_mask[0]); end
    total++; if (obs_addr[1] !== 32'h104 || obs_data[1] !== 32'h00001122 || obs_mask[1] !== 4'b0011) begin bad++; $display("FAIL split_beat1 got %h/%h/%b want 00000104/00001122/0011", obs_addr[1], obs_data[1], obs_mask[1]); end
    total++; if (obs_done_cyc !== 3) begin bad++; $display("FAIL split_done_cycle got %0d want 3", obs_done_cyc); end
  endtask

  task automatic test_stall_wrap();
    run_store(32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 3, 1'b1);
    total++; if (obs_nb !== 2) begin bad++; $display("FAIL wrap_beats got %0d want 2", obs_nb); end
    total++; if (obs_addr[0] !== 32'hFFFFFFFC || obs_data[0] !== 32'hEF000000 || obs_mask[0] !== 4'b1000) begin bad++; $display("FAIL wrap_beat0 got %h/%h/%b want fffffffc/ef000000/1000", obs_addr[0], obs_data[0], obs_mask[0]); end
    total++; if (obs_addr[1] !== 32'h0 || obs_data[1] !== 32'h000000BE || obs_mask[1] !== 4'b0001) begin bad++; $display("FAIL wrap_beat1 got %h/%h/%b want 00000000/000000be/0001", obs_addr[1], obs_data[1], obs_mask[1]); end
    total++; if (obs_unstable !== 1'b0) begin bad++; $display("FAIL wrap_stall_stable got unstable=%b want 0", obs_unstable); end
    total++; if (obs_done_cyc !== 9) begin bad++; $display("FAIL wrap_done_cycle got %0d want 9", obs_done_cyc); end
  endtask

  task automatic test_illegal();
    run_store(32'h300, 32'hCAFEF00D, 2'b11, 0, 1'b1);
    total++; if (obs_err_cyc !== 1 || obs_err_cnt !== 1) begin bad++; $display("FAIL illegal_err_pulse got cycle=%0d count=%0d want 1/1", obs_err_cyc, obs_err_cnt); end
    total++; if (obs_valid_seen !== 1'b0 || obs_done_cyc !== -1 || post_done !== 1'b0) begin bad++; $display("FAIL illegal_no_traffic got valid=%b done_cyc=%0d want 0/-1", obs_valid_seen, obs_done_cyc); end
    total++; if (post_ready !== 1'b1 || post_valid !== 1'b0) begin bad++; $display("FAIL illegal_ready_return got %b want 1", post_ready); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 32'h102; req_data = 32'h11223344; req_size = 2'b10; mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h104) begin bad++; $display("FAIL midrst_in_high got valid=%b addr=%h want 1/00000104", mem_valid, mem_addr); end
    #2 rst = 1'b1;
    #1;
    total++; if ({mem_valid, done, err} !== 3'b000 || req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ctrl got valid=%b done=%b err=%b ready=%b want 0/0/0/1", mem_valid, done, err, req_ready); end
    total++; if ({mem_addr, mem_wdata, mem_bmask} !== 68'b0) begin bad++; $display("FAIL midrst_bus got %h/%h/%b want 0", mem_addr, mem_wdata, mem_bmask); end
    @(posedge clk); #1;
    rst = 1'b0;
    run_store(32'h400, 32'h01020304, 2'b10, 1, 1'b0);
    total++; if (obs_nb !== 1 || obs_addr[0] !== 32'h400 || obs_data[0] !== 32'h01020304 || obs_mask[0] !== 4'b1111) begin bad++; $display("FAIL midrst_recover got n=%0d %h/%h/%b want 1 00000400/01020304/1111", obs_nb, obs_addr[0], obs_data[0], obs_mask[0]); end
    total++; if (obs_done_cyc !== 3) begin bad++; $display("FAIL midrst_recover_done got %0d want 3", obs_done_cyc); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          s;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; d = $urandom; sz = 2'($urandom_range(0, 3)); s = $urandom_range(0, 2);
      model_store(a, d, sz);
      run_store(a, d, sz, s, 1'b1);
      total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL rand_timeout iter=%0d got timeout want none", i); end
      total++; if (obs_nb !== exp_nb) begin bad++; $display("FAIL rand_beats iter=%0d got %0d want %0d", i, obs_nb, exp_nb); end
      for (int b = 0; b < exp_nb && b < obs_nb; b++) begin
        total++;
        if (obs_addr[b] !== exp_addr[b] || obs_data[b] !== exp_data[b] || obs_mask[b] !== exp_mask[b]) begin
          bad++; $display("FAIL rand_beat iter=%0d beat=%0d got %h/%h/%b want %h/%h/%b", i, b, obs_addr[b], obs_data[b], obs_mask[b], exp_addr[b], exp_data[b], exp_mask[b]);
        end
      end
      if (exp_ill) begin
        total++; if (obs_err_cnt !== 1 || obs_done_cyc !== -1) begin bad++; $display("FAIL rand_illegal iter=%0d got err=%0d done_cyc=%0d want 1/-1", i, obs_err_cnt, obs_done_cyc); end
      end else begin
        total++; if (obs_done_cyc !== exp_nb * (1 + s) + 1 || obs_err_cnt !== 0) begin bad++; $display("FAIL rand_done iter=%0d got cyc=%0d err=%0d want %0d/0", i, obs_done_cyc, obs_err_cnt, exp_nb * (1 + s) + 1); end
      end
      total++; if (obs_unstable !== 1'b0 || obs_both !== 1'b0) begin bad++; $display("FAIL rand_protocol iter=%0d got unstable=%b both=%b want 0/0", i, obs_unstable, obs_both); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_data = 0; req_size = 0; mem_ready = 1'b0;
    test_reset();
    test_aligned_word();
    test_byte_lanes();
    test_split_word();
    test_stall_wrap();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
